// File: rtl/seg_scan_driver.sv
// Multiplexed six-digit seven-segment scan driver.
// A prescaler divides each digit slot into SCAN_DIV cycles, with the first BLANK_CYC
// cycles of every slot dark to suppress ghosting. All six codes are captured into a
// shadow register once per frame, so a frame is always drawn from one consistent snapshot.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] DIG1,
    input  logic [4:0] DIG2,
    input  logic [4:0] DIG3,
    input  logic [4:0] DIG4,
    input  logic [4:0] DIG5,
    input  logic [4:0] DIG6,
    input  logic       LT,
    output logic [7:0] SEG,
    output logic [5:0] AN,
    output logic       FRAME
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);
    localparam logic [4:0]    CODE_BLANK = 5'b1_0000;

    // Code to active-low segment pattern {dp,g,f,e,d,c,b,a}; dp stays off.
    function automatic logic [7:0] decode(input logic [4:0] code);
        logic [7:0] seg;
        case (code)
            5'h00:   seg = 8'hC0;
            5'h01:   seg = 8'hF9;
            5'h02:   seg = 8'hA4;
            5'h03:   seg = 8'hB0;
            5'h04:   seg = 8'h99;
            5'h05:   seg = 8'h92;
            5'h06:   seg = 8'h82;
            5'h07:   seg = 8'hF8;
            5'h08:   seg = 8'h80;
            5'h09:   seg = 8'h90;
            5'h0A:   seg = 8'h88;
            5'h0B:   seg = 8'h83;
            5'h0C:   seg = 8'hC6;
            5'h0D:   seg = 8'hA1;
            5'h0E:   seg = 8'h86;
            5'h0F:   seg = 8'h8E;
            5'h11:   seg = 8'hBF;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    logic [5:0][4:0] dig_in;
    logic [5:0][4:0] shadow_q, shadow_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      seg_q, seg_d;
    logic [5:0]      an_q, an_d;
    logic            frame_q, frame_d;
    logic            load;
    logic            in_blank;
    logic [4:0]      cur_code;

    assign dig_in = {DIG6, DIG5, DIG4, DIG3, DIG2, DIG1};

    // Next-state: prescaler/index advance, shadow capture and registered output patterns.
    always_comb begin
        load     = (pcnt_q == '0) && (idx_q == 3'd0);
        pcnt_d   = pcnt_q + PW'(1);
        idx_d    = idx_q;
        if (pcnt_q == PCNT_LAST) begin
            pcnt_d = '0;
            idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        shadow_d = load ? dig_in : shadow_q;
        // Slot 0, cycle 0 is drawn from the snapshot being captured in that same cycle.
        case (idx_q)
            3'd0:    cur_code = shadow_d[0];
            3'd1:    cur_code = shadow_d[1];
            3'd2:    cur_code = shadow_d[2];
            3'd3:    cur_code = shadow_d[3];
            3'd4:    cur_code = shadow_d[4];
            3'd5:    cur_code = shadow_d[5];
            default: cur_code = CODE_BLANK;
        endcase
        in_blank = (pcnt_q < BLANK_LIM);
        if (in_blank) begin
            an_d  = 6'b111111;
            seg_d = 8'hFF;
        end else begin
            an_d  = ~(6'b000001 << idx_q);
            seg_d = LT ? 8'h00 : decode(cur_code);
        end
        frame_d = load;
    end

    // State and output registers; reset wins over lamp test and counting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt_q   <= '0;
            idx_q    <= 3'd0;
            shadow_q <= {6{CODE_BLANK}};
            an_q     <= 6'b111111;
            seg_q    <= 8'hFF;
            frame_q  <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            frame_q  <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=2 (48-cycle frame).
module tb_seg_scan_driver;

    logic       clk;
    logic       rst;
    logic [4:0] dig1, dig2, dig3, dig4, dig5, dig6;
    logic       lt;
    logic [7:0] seg;
    logic [5:0] an;
    logic       frame;

    int checks   = 0;
    int failures = 0;
    int s        = 0;   // index of the counter state the sampled outputs reflect
    logic lt_ref = 1'b0;

    logic [7:0] an_tab  [6] = '{8'h3E, 8'h3D, 8'h3B, 8'h37, 8'h2F, 8'h1F};
    logic [7:0] seg_tab [6];

    seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .CLK(clk), .RST(rst),
        .DIG1(dig1), .DIG2(dig2), .DIG3(dig3), .DIG4(dig4), .DIG5(dig5), .DIG6(dig6),
        .LT(lt), .SEG(seg), .AN(an), .FRAME(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s s=%0d observed=%h expected=%h", tag, s, obs, exp);
        end
    endtask

    // Sample n consecutive cycles; slot expectations come from an_tab/seg_tab.
    task automatic run(input int n);
        int p;
        int i;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            p = s % 8;
            i = (s / 8) % 6;
            chk("frame", {7'b0, frame}, (s % 48 == 0) ? 8'h01 : 8'h00);
            if (p < 2) begin
                chk("an_blank", {2'b0, an}, 8'h3F);
                chk("seg_blank", seg, 8'hFF);
            end else begin
                chk("an", {2'b0, an}, an_tab[i]);
                chk("seg", seg, lt_ref ? 8'h00 : seg_tab[i]);
            end
            $display("cyc s=%0d an=%b seg=%h frame=%b", s, an, seg, frame);
            s++;
        end
    endtask

    initial begin
        rst = 1'b1; lt = 1'b0;
        dig1 = 5'h10; dig2 = 5'h10; dig3 = 5'h10;
        dig4 = 5'h10; dig5 = 5'h10; dig6 = 5'h10;
        repeat (2) @(negedge clk);
        chk("rst_an", {2'b0, an}, 8'h3F);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_frame", {7'b0, frame}, 8'h00);

        // Frame A: only DIG1 = 3
        dig1 = 5'h03;
        seg_tab = '{8'hB0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        rst = 1'b0;
        s = 0;
        run(48);

        // Frame B: special codes, DIG4 = 5 at load time
        dig1 = 5'h10; dig2 = 5'h11; dig3 = 5'h17;
        dig4 = 5'h05; dig5 = 5'h0F; dig6 = 5'h10;
        seg_tab = '{8'hFF, 8'hBF, 8'hFF, 8'h92, 8'h8E, 8'hFF};
        run(20);
        dig4 = 5'h0A;   // changed during slot 2; must not affect this frame
        run(28);

        // Frame C: new DIG4 value takes effect
        seg_tab[3] = 8'h88;
        run(48);

        // Frame D: lamp test from slot 1 cycle 4 to slot 3 cycle 5
        run(12);
        lt = 1'b1; lt_ref = 1'b1;
        run(18);
        lt = 1'b0; lt_ref = 1'b0;
        run(18);

        // Reset pulse at PCNT=5, IDX=3, with lamp test also requested
        run(29);
        rst = 1'b1; lt = 1'b1;
        @(negedge clk);
        chk("midrst_an", {2'b0, an}, 8'h3F);
        chk("midrst_seg", seg, 8'hFF);
        chk("midrst_frame", {7'b0, frame}, 8'h00);
        $display("cyc reset an=%b seg=%h frame=%b", an, seg, frame);
        rst = 1'b0; lt = 1'b0; lt_ref = 1'b0;
        s = 0;
        run(56);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
